nibble_lane_sched: RTL and testbench

Scheduler for the nibble-lane shifter datapath. The shifter places a 4-bit operand into an 8-bit result at bit offset 4*lane.
- Arbitrates NREQ nibble sources round-robin.
- Locks the granted source for one full byte (two nibbles, lane 0 then lane 1).
- Drives the lane select for each nibble.
- Presents the assembled byte on a valid/ready output register.
- Sits between nibble producers and any byte-wide consumer.

---
 rtl/nibble_lane_sched_if.sv | 26 ++
 rtl/nibble_lane_sched.sv | 108 ++++++++++
 tb/tb_nibble_lane_sched.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_lane_sched_if.sv
// Nibble-lane scheduler bus: per-requester nibble handshake plus the byte-wide
// valid/ready output toward the consumer.
interface nibble_lane_sched_if #(
  parameter int NREQ = 2,
  parameter int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_nib;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [7:0]        out_byte;
  logic [SW-1:0]     out_src;
  logic              out_ready;

  // Producers and consumer side.
  modport master (
    output req_valid, req_nib, out_ready,
    input  req_ready, out_valid, out_byte, out_src
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_nib, out_ready,
    output req_ready, out_valid, out_byte, out_src
  );
endinterface

// File: rtl/nibble_lane_sched.sv
// Round-robin scheduler that locks one nibble source for a whole byte, assembles
// lane 0 then lane 1, and holds the finished byte on a valid/ready register.
module nibble_lane_sched #(
  parameter int NREQ = 2,
  parameter int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  nibble_lane_sched_if.slave bus,
  output logic               busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GATHER = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [1:0]    state;
  logic          lane;
  logic [7:0]    acc;
  logic [SW-1:0] gnt;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] pick;
  logic          any_req;
  logic [SW:0]   scan_idx;
  logic          found;
  logic [3:0]    cur_nib;
  logic          accept;
  logic [7:0]    merged;
  logic [7:0]    out_byte_q;
  logic [SW-1:0] out_src_q;
  logic          out_valid_q;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = '0;
    any_req  = |bus.req_valid;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (SW+1)'(k);
      if (scan_idx >= (SW+1)'(NREQ)) begin
        scan_idx = scan_idx - (SW+1)'(NREQ);
      end
      if (!found && bus.req_valid[scan_idx[SW-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[SW-1:0];
      end
    end
  end

  assign cur_nib = bus.req_nib[{gnt, 2'b00} +: 4];
  assign accept  = (state == GATHER) && bus.req_valid[gnt];
  assign merged  = acc | ({4'b0000, cur_nib} << {lane, 2'b00});

  assign bus.req_ready = (state == GATHER) ? (NREQ'(1) << gnt) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_src   = out_src_q;
  assign busy          = (state != IDLE);

  // The lock on gnt is only released from HOLD; a stalled owner blocks everyone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lane        <= 1'b0;
      acc         <= '0;
      gnt         <= '0;
      rr_ptr      <= '0;
      out_byte_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= pick;
            lane  <= 1'b0;
            acc   <= '0;
            state <= GATHER;
          end
        end
        GATHER: begin
          if (accept) begin
            acc <= merged;
            if (lane) begin
              lane        <= 1'b0;
              out_byte_q  <= merged;
              out_src_q   <= gnt;
              out_valid_q <= 1'b1;
              state       <= HOLD;
            end else begin
              lane <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            rr_ptr      <= (gnt == SW'(NREQ-1)) ? '0 : gnt + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_lane_sched.sv
// Self-checking bench for nibble_lane_sched: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_nibble_lane_sched;

  localparam int NREQ = 2;
  localparam int SW   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  int checks = 0;
  int errors = 0;

  // Reference model: owner < 0 means nobody holds the lock.
  int m_owner;
  int m_count;
  int m_acc;
  bit m_hold;
  int m_out_byte;
  int m_out_src;
  int m_ptr;

  nibble_lane_sched_if #(.NREQ(NREQ)) bus ();

  nibble_lane_sched #(.NREQ(NREQ)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_owner    = -1;
    m_count    = 0;
    m_acc      = 0;
    m_hold     = 1'b0;
    m_out_byte = 0;
    m_out_src  = 0;
    m_ptr      = 0;
  endtask

  task automatic model_step();
    int c;
    int n;
    if (rst) begin
      model_clear();
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (m_owner < 0 && bus.req_valid[c]) begin
          m_owner = c;
          m_count = 0;
          m_acc   = 0;
        end
      end
    end else if (!m_hold) begin
      if (bus.req_valid[m_owner]) begin
        n = int'((bus.req_nib >> (4 * m_owner)) & 8'h0F);
        m_acc = m_acc + n * ((m_count == 0) ? 1 : 16);
        m_count++;
        if (m_count == 2) begin
          m_out_byte = m_acc;
          m_out_src  = m_owner;
          m_hold     = 1'b1;
        end
      end
    end else if (bus.out_ready) begin
      m_hold  = 1'b0;
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
    end
  endtask

  task automatic compare_all();
    int exp_ready;
    exp_ready = (m_owner >= 0 && !m_hold) ? (1 << m_owner) : 0;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(m_hold));
    checkOutput("out_byte",  32'(bus.out_byte),  32'(m_out_byte));
    checkOutput("out_src",   32'(bus.out_src),   32'(m_out_src));
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    checkOutput("busy",      32'(busy),          32'(m_owner >= 0));
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [4*NREQ-1:0] n, input logic r);
    bus.req_valid = v;
    bus.req_nib   = n;
    bus.out_ready = r;
    step_cycle();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    model_clear();
    compare_all();
    repeat (cycles) step_cycle();
    rst = 1'b0;
  endtask

  initial begin
    int bytes_seen;
    bit prev_valid;
    logic [3:0] n0;
    logic [3:0] n1;

    bus.req_valid = '0;
    bus.req_nib   = '0;
    bus.out_ready = 1'b0;
    model_clear();

    // Reset then idle
    do_reset(3);
    repeat (10) begin
      applyStimulus(2'b00, 8'h00, 1'b0);
      checkOutput("idle_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("idle_byte",  32'(bus.out_byte),  32'h00);
    end

    // Single byte, 0x3 then 0xA from requester 0
    applyStimulus(2'b01, 8'h03, 1'b1);
    checkOutput("single_busy", 32'(busy), 32'd1);
    applyStimulus(2'b01, 8'h03, 1'b1);
    checkOutput("single_early", 32'(bus.out_valid), 32'd0);
    applyStimulus(2'b01, 8'h0A, 1'b1);
    checkOutput("single_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("single_byte",  32'(bus.out_byte),  32'hA3);
    checkOutput("single_src",   32'(bus.out_src),   32'd0);
    applyStimulus(2'b00, 8'h00, 1'b1);
    checkOutput("single_drop", 32'(bus.out_valid), 32'd0);

    // Round-robin with both requesters always valid
    do_reset(1);
    bytes_seen = 0;
    prev_valid = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      n0 = (m_owner == 0 && m_count == 1) ? 4'h2 : 4'h1;
      n1 = (m_owner == 1 && m_count == 1) ? 4'hF : 4'hE;
      applyStimulus(2'b11, {n1, n0}, 1'b1);
      if (bus.out_valid && !prev_valid) begin
        checkOutput("rr_byte", 32'(bus.out_byte), (bytes_seen % 2 == 0) ? 32'h21 : 32'hFE);
        checkOutput("rr_src",  32'(bus.out_src),  32'(bytes_seen % 2));
        bytes_seen++;
      end
      prev_valid = bus.out_valid;
    end
    checkOutput("rr_count", 32'(bytes_seen), 32'd4);

    // Backpressure on byte 0x5C
    do_reset(1);
    applyStimulus(2'b01, 8'h0C, 1'b0);
    applyStimulus(2'b01, 8'h0C, 1'b0);
    applyStimulus(2'b01, 8'h05, 1'b0);
    repeat (5) begin
      applyStimulus(2'b01, 8'h05, 1'b0);
      checkOutput("bp_byte",  32'(bus.out_byte),  32'h5C);
      checkOutput("bp_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    applyStimulus(2'b01, 8'h05, 1'b1);
    checkOutput("bp_release", 32'(bus.out_valid), 32'd0);

    // Lock held while the owner stalls mid-byte
    do_reset(1);
    applyStimulus(2'b01, 8'h07, 1'b0);
    applyStimulus(2'b01, 8'h07, 1'b0);
    repeat (4) begin
      applyStimulus(2'b10, 8'hB0, 1'b0);
      checkOutput("lock_ready", 32'(bus.req_ready), 32'h1);
    end
    applyStimulus(2'b11, 8'hB9, 1'b0);
    checkOutput("lock_byte", 32'(bus.out_byte), 32'h97);
    checkOutput("lock_src",  32'(bus.out_src),  32'd0);
    applyStimulus(2'b11, 8'hB9, 1'b1);
    applyStimulus(2'b11, 8'hB9, 1'b0);
    checkOutput("lock_next", 32'(bus.req_ready), 32'h2);

    // Reset in the middle of a byte
    do_reset(1);
    applyStimulus(2'b01, 8'h04, 1'b0);
    applyStimulus(2'b01, 8'h04, 1'b0);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    do_reset(2);
    checkOutput("mid_clr_byte", 32'(bus.out_byte), 32'h00);
    checkOutput("mid_clr_busy", 32'(busy), 32'd0);
    applyStimulus(2'b01, 8'h01, 1'b1);
    applyStimulus(2'b01, 8'h01, 1'b1);
    applyStimulus(2'b01, 8'h02, 1'b1);
    checkOutput("mid_byte", 32'(bus.out_byte), 32'h21);

    // Random traffic against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(1);
      end else begin
        applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
